spi_ram_master_ctrl: RTL and testbench

- Command-level master that sequences SPI frames into the SPI-slave + RAM subsystem (MOSI/MISO/SS_n/clk side).
- Accepts one RAM write or RAM read per command over a valid/ready handshake.
- Expands each command into two SPI frames: address frame, then data frame.
- Read data is captured from MISO and returned with a one-cycle response strobe.

---
 rtl/spi_ram_master_ctrl_if.sv | 26 ++
 rtl/spi_ram_master_ctrl.sv | 153 +++++++++++++++
 tb/tb_spi_ram_master_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_ctrl_if.sv
// Command, response and SPI pin bundle for spi_ram_master_ctrl.
// master: controller side (takes commands and MISO, drives ready/response/busy/MOSI/SS_n).
// slave : the side that feeds commands and models the SPI slave.
interface spi_ram_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       MOSI;
  logic       MISO;
  logic       SS_n;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, MISO,
    output cmd_ready, rsp_valid, rsp_rdata, busy, MOSI, SS_n
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, MISO,
    input  cmd_ready, rsp_valid, rsp_rdata, busy, MOSI, SS_n
  );
endinterface

// File: rtl/spi_ram_master_ctrl.sv
// Command-level SPI master: each RAM write/read command becomes an address
// frame then a data frame (11 bits MSB-first, SS_n low), reads capture 8 MISO
// bits after RD_LAT clocks. Ports: clk, rst (sync, active-high), bus (master
// modport: cmd_valid/ready/rw/addr/wdata, rsp_valid/rdata, busy, MOSI/MISO/SS_n).
module spi_ram_master_ctrl #(
  parameter int ADDR_W = 8,  // frame payload is 8 bits wide, so this stays 8
  parameter int RD_LAT = 2,  // must be >= 1
  parameter int GAP    = 2   // must be >= 1
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_master_ctrl_if.master bus
);
  localparam int MAX_A   = (RD_LAT > GAP) ? RD_LAT : GAP;
  localparam int CNT_MAX = (MAX_A > 11) ? MAX_A : 11;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_WAIT_RD, S_CAPTURE, S_GAP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [9:0]        sreg;        // frame bits still to be shifted out
  logic [6:0]        cap_sr;      // first 7 MISO samples
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_wdata;
  logic              data_phase;  // 0: address frame, 1: data frame

  logic              cmd_ready_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic [7:0]        rsp_rdata_q;
  logic              mosi_q;
  logic              ss_n_q;

  logic [1:0]        fcmd;
  logic [7:0]        payload;
  logic [10:0]       frame;

  // Frame = {cmd[1], cmd[1:0], payload}; cmd = {rw, data_phase}.
  always_comb begin
    fcmd    = {lat_rw, data_phase};
    payload = 8'(lat_addr);
    if (data_phase) begin
      payload = lat_rw ? 8'h00 : lat_wdata;
    end
    frame = {fcmd[1], fcmd, payload};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sreg        <= '0;
      cap_sr      <= '0;
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      data_phase  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            lat_rw      <= bus.cmd_rw;
            lat_addr    <= bus.cmd_addr;
            lat_wdata   <= bus.cmd_wdata;
            data_phase  <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= S_LOAD;
          end
        end
        // SS_n and the first bit go out together on the exit edge, so the
        // low period is exactly the 11 SHIFT cycles.
        S_LOAD: begin
          mosi_q <= frame[10];
          sreg   <= frame[9:0];
          ss_n_q <= 1'b0;
          cnt    <= '0;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(10)) begin
            cnt    <= '0;
            mosi_q <= 1'b0;
            if (fcmd == 2'b11) begin
              state <= S_WAIT_RD;
            end else begin
              ss_n_q <= 1'b1;
              state  <= S_GAP;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            mosi_q <= sreg[9];
            sreg   <= {sreg[8:0], 1'b0};
          end
        end
        S_WAIT_RD: begin
          if (cnt == CNT_W'(RD_LAT - 1)) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          cap_sr <= {cap_sr[5:0], bus.MISO};
          if (cnt == CNT_W'(7)) begin
            rsp_rdata_q <= {cap_sr, bus.MISO};
            rsp_valid_q <= 1'b1;
            ss_n_q      <= 1'b1;
            cnt         <= '0;
            state       <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            cnt <= '0;
            if (!data_phase) begin
              data_phase <= 1'b1;
              state      <= S_LOAD;
            end else begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state       <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.MOSI      = mosi_q;
  assign bus.SS_n      = ss_n_q;
endmodule

// File: tb/tb_spi_ram_master_ctrl.sv
// Directed bench for spi_ram_master_ctrl with an SPI-slave + RAM model on the pins.
module tb_spi_ram_master_ctrl;
  localparam int RD_LAT = 2;
  localparam int GAP    = 2;
  localparam int RD_LEN = 11 + RD_LAT + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_master_ctrl_if bus();

  spi_ram_master_ctrl #(.ADDR_W(8), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI slave + RAM model: decodes completed 11-bit frames, serves read data.
  typedef struct {
    logic [10:0] bits;
    int          len;
    int          gap;
    logic        rsp;
  } frm_t;

  frm_t        frames [64];
  int          n_frames    = 0;
  int          low_periods = 0;
  logic [7:0]  mem [256]   = '{default: 8'h00};
  logic [10:0] cur_bits    = '0;
  int          idx         = 0;
  int          high_run    = 0;
  int          cur_gap     = 0;
  logic [7:0]  s_addr      = 8'h00;

  always @(negedge clk) begin
    int j;
    if (bus.SS_n === 1'b0) begin
      if (idx == 0) begin
        low_periods++;
        cur_gap = high_run;
      end
      j = idx;
      if (j < 11) cur_bits = {cur_bits[9:0], bus.MOSI};
      if (j >= 11 + RD_LAT && j < 19 + RD_LAT && cur_bits[9:8] == 2'b11)
        bus.MISO = mem[s_addr][7 - (j - 11 - RD_LAT)];
      else
        bus.MISO = 1'($urandom);
      idx++;
    end else begin
      if (idx >= 11 && n_frames < 64) begin
        case (cur_bits[9:8])
          2'b00, 2'b10: s_addr = cur_bits[7:0];
          2'b01:        mem[s_addr] = cur_bits[7:0];
          default: ;
        endcase
        frames[n_frames] = '{bits: cur_bits, len: idx, gap: cur_gap, rsp: bus.rsp_valid};
        n_frames++;
      end
      if (idx != 0) high_run = 0;
      idx = 0;
      high_run++;
      bus.MISO = 1'($urandom);
    end
  end

  // Response monitor
  int         rsp_cnt  = 0;
  int         rsp_wide = 0;
  logic [7:0] last_rsp = 8'h00;
  logic       prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp = bus.rsp_rdata;
      if (prev_rsp) rsp_wide++;
    end
    prev_rsp = bus.rsp_valid;
  end

  // mode 0: drop valid after accept; 1: keep valid high; 2: randomise inputs while busy.
  // Called and returns at a negedge; n counts edges from the accept edge to cmd_ready.
  task automatic run_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d,
                         input int mode, output int n, output int waited, output int busy_low);
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    @(posedge clk);
    n = 1;
    busy_low = 0;
    t = 0;
    @(negedge clk);
    if (mode == 0) bus.cmd_valid = 1'b0;
    while (bus.cmd_ready !== 1'b1 && t < 200) begin
      if (bus.busy !== 1'b1) busy_low++;
      if (mode == 2) begin
        bus.cmd_valid = 1'($urandom);
        bus.cmd_rw    = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = 8'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      t++;
    end
    if (mode != 1) bus.cmd_valid = 1'b0;
  endtask

  int rd_ptr = 0;

  task automatic check_frames(input string tag, input logic [10:0] fa, input logic [10:0] fb,
                              input int len_b, input logic rsp_b);
    check({tag, "_nframes"}, 32'(n_frames - rd_ptr >= 2), 32'd1);
    if (n_frames - rd_ptr >= 2) begin
      check({tag, "_fa"},    32'(frames[rd_ptr].bits),     32'(fa));
      check({tag, "_fa_len"}, frames[rd_ptr].len,          11);
      check({tag, "_fb"},    32'(frames[rd_ptr + 1].bits), 32'(fb));
      check({tag, "_fb_len"}, frames[rd_ptr + 1].len,      len_b);
      check({tag, "_gap"},    frames[rd_ptr + 1].gap,      GAP + 1);
      check({tag, "_rsp_at_gap"}, 32'(frames[rd_ptr + 1].rsp), 32'(rsp_b));
      rd_ptr += 2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w, bl, lp0, r0, w2, w3, w4;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_wdata = 8'h00;

    // Reset, then a 3-clock reset in the middle of idle
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n",      32'(bus.SS_n),      32'd1);
    check("rst_mosi",      32'(bus.MOSI),      32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.cmd_ready), 32'd1);

    // Write 3C <- A5
    r0 = rsp_cnt;
    run_cmd(1'b0, 8'h3C, 8'hA5, 0, n, w, bl);
    check("wr_latency", n, 29);
    check("wr_busy_held", bl, 0);
    check_frames("wr3c", 11'h03C, 11'h1A5, 11, 1'b0);
    check("wr_golden_ram", 32'(mem[8'h3C]), 32'hA5);
    check("wr_no_rsp", rsp_cnt - r0, 0);

    // Read 3C
    r0 = rsp_cnt;
    run_cmd(1'b1, 8'h3C, 8'h00, 0, n, w, bl);
    check("rd_latency", n, 39);
    check("rd_busy_held", bl, 0);
    check_frames("rd3c", 11'h63C, 11'h700, RD_LEN, 1'b1);
    check("rd_rsp_count", rsp_cnt - r0, 1);
    check("rd_rsp_value", 32'(last_rsp), 32'hA5);
    check("rd_rdata_held", 32'(bus.rsp_rdata), 32'hA5);

    // Back-to-back with cmd_valid held high
    lp0 = low_periods;
    r0  = rsp_cnt;
    run_cmd(1'b0, 8'h00, 8'h11, 1, n, w, bl);
    check("b2b_wr00_latency", n, 29);
    run_cmd(1'b0, 8'hFF, 8'h22, 1, n, w2, bl);
    check("b2b_wrff_latency", n, 29);
    run_cmd(1'b1, 8'h00, 8'h00, 1, n, w3, bl);
    check("b2b_rd00_latency", n, 39);
    check("b2b_rd00_value", 32'(last_rsp), 32'h11);
    run_cmd(1'b1, 8'hFF, 8'h00, 0, n, w4, bl);
    check("b2b_rdff_latency", n, 39);
    check("b2b_rdff_value", 32'(last_rsp), 32'h22);
    check("b2b_idle_1cycle", w2 + w3 + w4, 0);
    check("b2b_ss_low_periods", low_periods - lp0, 8);
    check("b2b_rsp_count", rsp_cnt - r0, 2);
    check_frames("b2b_wr00", 11'h000, 11'h111, 11, 1'b0);
    check_frames("b2b_wrff", 11'h0FF, 11'h122, 11, 1'b0);
    check_frames("b2b_rd00", 11'h600, 11'h700, RD_LEN, 1'b1);
    check_frames("b2b_rdff", 11'h6FF, 11'h700, RD_LEN, 1'b1);

    // cmd_valid/data toggled while busy must not disturb the latched command
    run_cmd(1'b0, 8'h5A, 8'hC3, 2, n, w, bl);
    check("tog_latency", n, 29);
    check_frames("tog_wr5a", 11'h05A, 11'h1C3, 11, 1'b0);
    run_cmd(1'b1, 8'h5A, 8'h00, 0, n, w, bl);
    check("tog_rd_value", 32'(last_rsp), 32'hC3);
    check_frames("tog_rd5a", 11'h65A, 11'h700, RD_LEN, 1'b1);

    // Reset during bit 5 of a read-data frame
    r0 = rsp_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_ss_low_before", 32'(bus.SS_n), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ss_n",      32'(bus.SS_n),      32'd1);
    check("abort_mosi",      32'(bus.MOSI),      32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_ready",     32'(bus.cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
    rst = 1'b0;
    lp0 = low_periods;
    repeat (40) @(negedge clk);
    check("abort_no_rsp", rsp_cnt - r0, 0);
    check("abort_no_frames", low_periods - lp0, 0);
    check("abort_one_frame", n_frames - rd_ptr, 1);
    if (n_frames - rd_ptr == 1) begin
      check("abort_addr_frame", 32'(frames[rd_ptr].bits), 32'h6FF);
      rd_ptr++;
    end
    run_cmd(1'b1, 8'hFF, 8'h00, 0, n, w, bl);
    check("post_abort_latency", n, 39);
    check("post_abort_value", 32'(last_rsp), 32'h22);
    check_frames("post_abort_rdff", 11'h6FF, 11'h700, RD_LEN, 1'b1);
    check("rsp_single_pulse", rsp_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
